// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode constants and FSM encoding for the round-robin logic-unit arbiter.
package logic_unit_arbiter_pkg;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Shared combinational bitwise logic unit: y = op(a, b); b is ignored for NOT.
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter over four requesters feeding one shared logic unit.
// One transaction at a time: IDLE (grant+capture) -> EXEC (compute) -> RESP (hold until ready).
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      out_data,
  output logic [1:0]            out_id,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       id_q, id_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_id_q, out_id_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] lu_y;

  // Search upward from ptr with 2-bit wraparound; first live request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic_unit #(.WIDTH(WIDTH)) u_lu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (lu_y)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          op_d    = op[2*win_idx +: 2];
          a_d     = a_in[win_idx*WIDTH +: WIDTH];
          b_d     = b_in[win_idx*WIDTH +: WIDTH];
          id_d    = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          ptr_d   = win_idx + 2'd1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_data_d = lu_y;
        out_id_d   = id_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_valid = (state_q == ST_RESP);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: inputs driven and outputs sampled on falling clk edges.
module tb_logic_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed results for a=F0, b=3C with ops AND/OR/XOR/NOT on lanes 0..3.
  function automatic logic [7:0] rr_exp(input int id);
    case (id)
      0:       return 8'h30;
      1:       return 8'hFC;
      2:       return 8'hCC;
      default: return 8'h0F;
    endcase
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; op = '0; a_in = '0; b_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", out_data); end
    n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", out_id); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single_not();
    a_in = {24'h0, 8'hA5}; op = 8'h00; req = 4'b0001;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    req = 4'b0000;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== 8'h5A) begin n_fail++; $display("FAIL single_data got=%h exp=5a", out_data); end
    n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL single_id got=%0d exp=0", out_id); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    op   = 8'b00_11_10_01;
    a_in = {4{8'hF0}};
    b_in = {4{8'h3C}};
    req  = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      logic [3:0] eg;
      int id;
      id = t % 4;
      eg = 4'b0001 << id;
      @(negedge clk);
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", t, gnt, eg); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got=%b exp=1", t, out_valid); end
      n_checks++; if (out_data !== rr_exp(id)) begin n_fail++; $display("FAIL rr_data[%0d] got=%h exp=%h", t, out_data, rr_exp(id)); end
      n_checks++; if (out_id !== 2'(id)) begin n_fail++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", t, out_id, id); end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d] got=%b exp=0", t, out_valid); end
    end
  endtask

  task automatic test_wrap();
    req = 4'b1001;
    for (int t = 0; t < 3; t++) begin
      int id;
      logic [3:0] eg;
      id = (t == 1) ? 3 : 0;
      eg = 4'b0001 << id;
      @(negedge clk);
      n_checks++; if (gnt !== eg) begin n_fail++; $display("FAIL wrap_gnt[%0d] got=%b exp=%b", t, gnt, eg); end
      if (t == 2) req = 4'b0000;
      @(negedge clk);
      n_checks++; if (out_data !== rr_exp(id)) begin n_fail++; $display("FAIL wrap_data[%0d] got=%h exp=%h", t, out_data, rr_exp(id)); end
      n_checks++; if (out_id !== 2'(id)) begin n_fail++; $display("FAIL wrap_id[%0d] got=%0d exp=%0d", t, out_id, id); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    req = 4'b0010;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL stall_gnt got=%b exp=0010", gnt); end
    req = 4'b0001; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin n_fail++; $display("FAIL stall_first valid=%b id=%0d exp valid=1 id=1", out_valid, out_id); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=1", c, out_valid); end
      n_checks++; if (out_data !== 8'hFC) begin n_fail++; $display("FAIL stall_data[%0d] got=%h exp=fc", c, out_data); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_gnt[%0d] got=%b exp=0000", c, gnt); end
    end
    req = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got=%b exp=0", out_valid); end
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL stall_withdrawn_gnt got=%b exp=0000", gnt); end
  endtask

  task automatic test_withdraw();
    req = 4'b0010;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL wd_gnt got=%b exp=0010", gnt); end
    req = 4'b0100; out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin n_fail++; $display("FAIL wd_owner valid=%b id=%0d exp valid=1 id=1", out_valid, out_id); end
    req = 4'b0000;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wd_busy_gnt got=%b exp=0000", gnt); end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wd_gnt[%0d] got=%b exp=0000", c, gnt); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wd_valid[%0d] got=%b id=%0d exp valid=0", c, out_valid, out_id); end
    end
  endtask

  task automatic test_reset_midflight();
    req = 4'b0001;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_gnt got=%b exp=0001", gnt); end
    req = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_gnt got=%b exp=0000", gnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got=%h exp=00", out_data); end
    n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL mid_rst_id got=%0d exp=0", out_id); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid[%0d] got=%b exp=0", c, out_valid); end
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_post_gnt[%0d] got=%b exp=0000", c, gnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single_not();
    test_round_robin();
    test_wrap();
    test_stall();
    test_withdraw();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (fixed at 4; other values unsupported).
REQ-003 SHALL have a single clock and an asynchronous, active-low reset; all state changes on rising clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  4  per-requester request; bit i held high until gnt[i] is seen.
REQ-007 op  input  8  2-bit opcode per requester, op[2i+1:2i]; 00 NOT a, 01 AND, 10 OR, 11 XOR.
REQ-008 a_in  input  4*WIDTH  operand A per requester, slice i = a_in[i*WIDTH +: WIDTH].
REQ-009 b_in  input  4*WIDTH  operand B per requester, same slicing; ignored for NOT.
REQ-010 gnt  output  4  one-hot, one-cycle pulse marking the accepted requester.
REQ-011 out_data  output  WIDTH  result of the granted operation.
REQ-012 out_id  output  2  index of the requester that owns out_data.
REQ-013 out_valid  output  1  result valid; held until accepted.
REQ-014 out_ready  input  1  consumer accepts result when high with out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 IDLE: if any req bit high at a rising edge, select a winner round-robin, capture its op/a/b and index, pulse gnt[winner] for the next cycle, go to EXEC; else stay IDLE.
REQ-017 Round-robin: search starts at priority pointer ptr (2 bits), ascending modulo 4; after a grant ptr becomes winner+1 modulo 4 (3 wraps to 0).
REQ-018 EXEC: compute result from captured operands via the shared logic unit, register into out_data/out_id, go to RESP; exactly one cycle.
REQ-019 RESP: out_valid=1; out_data/out_id stable; on out_ready=1 go to IDLE with out_valid=0 the next cycle.
REQ-020 Latency: gnt high in cycle N+1, out_valid first high in cycle N+2 after capture edge N; minimum 3 cycles per transaction with out_ready tied high.
REQ-021 No new request is evaluated outside IDLE; req changes during EXEC/RESP SHALL NOT affect the in-flight result.
REQ-022 A req bit dropped before its grant is treated as withdrawn; no grant, no result.
REQ-023 Simultaneous requests: exactly one grant per transaction; gnt never has more than one bit set.
REQ-024 out_ready high outside RESP SHALL be ignored.
REQ-025 NOT result is bitwise ~a; all ops bitwise over WIDTH, no carries.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, ptr=0, gnt=0, out_valid=0, out_data=0, out_id=0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; no result delivered after release.
REQ-028 First grant after reset SHALL follow priority order 0,1,2,3.

Structure
REQ-029 Shared package SHALL hold opcode constants (OP_NOT, OP_AND, OP_OR, OP_XOR) and FSM state encodings.
REQ-030 Combinational datapath SHALL be a separate sub-module logic_unit (op, a, b -> y), instantiated once and shared.

Verification
REQ-031 Reset then req=0001, op0=00, a0=8'hA5, out_ready=1 -> gnt=0001 one cycle, out_valid with out_data=8'h5A, out_id=0.
REQ-032 req=1111 held, ops AND/OR/XOR/NOT, a=8'hF0, b=8'h3C -> grant order 0,1,2,3, results 30,FC,CC,0F, then order repeats 0,1,...
REQ-033 After grant of 3, req=1001 -> next grant 0 (pointer wrap), then 3.
REQ-034 out_ready=0 for 5 cycles in RESP -> out_valid and out_data stable all 5 cycles, no gnt issued; release -> IDLE.
REQ-035 rst_n low during EXEC -> all outputs 0 immediately; after release with req=0000 no out_valid ever appears.
REQ-036 req[2] pulsed high then low while busy on requester 1 -> no gnt[2], no result with out_id=2.
